// File: rtl/pulse_train_gen.sv
// Multi-channel pulse-train generator: each channel plays a programmable
// delay / high / low pattern for a finite pulse count or continuously.
module pulse_train_gen #(
  parameter int CHANNELS = 4,
  parameter int CH_W     = 2,
  parameter int CNT_W    = 8,
  parameter int NUM_W    = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [CNT_W-1:0]    cfg_dly,
  input  logic [CNT_W-1:0]    cfg_high,
  input  logic [CNT_W-1:0]    cfg_low,
  input  logic [NUM_W-1:0]    cfg_num,
  input  logic                cfg_cont,
  input  logic [CHANNELS-1:0] start,
  input  logic [CHANNELS-1:0] stop,
  output logic [CHANNELS-1:0] signal,
  output logic [CHANNELS-1:0] busy,
  output logic [CHANNELS-1:0] done
);

  typedef enum logic [1:0] {IDLE, DELAY, HIGH, LOW} state_t;

  logic [CNT_W-1:0]    c_dly  [CHANNELS];
  logic [CNT_W-1:0]    c_high [CHANNELS];
  logic [CNT_W-1:0]    c_low  [CHANNELS];
  logic [NUM_W-1:0]    c_num  [CHANNELS];
  logic [CHANNELS-1:0] c_cont;

  logic [CNT_W-1:0]    w_high [CHANNELS];
  logic [CNT_W-1:0]    w_low  [CHANNELS];
  logic [CHANNELS-1:0] w_cont;

  state_t              state    [CHANNELS];
  state_t              state_nx [CHANNELS];
  logic [CNT_W-1:0]    cnt      [CHANNELS];
  logic [CNT_W-1:0]    cnt_nx   [CHANNELS];
  logic [NUM_W-1:0]    rem      [CHANNELS];
  logic [NUM_W-1:0]    rem_nx   [CHANNELS];
  logic [CHANNELS-1:0] done_r;
  logic [CHANNELS-1:0] done_nx;
  logic [CHANNELS-1:0] accept;

  // Phase lengths of 0 behave as 1, so the reload value saturates at 0.
  function automatic logic [CNT_W-1:0] len_m1(input logic [CNT_W-1:0] v);
    return (v == '0) ? '0 : v - CNT_W'(1);
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        c_dly[i]  <= '0;
        c_high[i] <= CNT_W'(1);
        c_low[i]  <= CNT_W'(1);
        c_num[i]  <= NUM_W'(1);
      end
      c_cont <= '0;
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (cfg_we && cfg_ch == CH_W'(i)) begin
          c_dly[i]  <= cfg_dly;
          c_high[i] <= cfg_high;
          c_low[i]  <= cfg_low;
          c_num[i]  <= cfg_num;
          c_cont[i] <= cfg_cont;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        state[i]  <= IDLE;
        cnt[i]    <= '0;
        rem[i]    <= '0;
        w_high[i] <= '0;
        w_low[i]  <= '0;
      end
      w_cont <= '0;
      done_r <= '0;
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        state[i] <= state_nx[i];
        cnt[i]   <= cnt_nx[i];
        rem[i]   <= rem_nx[i];
        if (accept[i]) begin
          w_high[i] <= c_high[i];
          w_low[i]  <= c_low[i];
          w_cont[i] <= c_cont[i];
        end
      end
      done_r <= done_nx;
    end
  end

  always_comb begin
    accept  = '0;
    done_nx = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      state_nx[i] = state[i];
      cnt_nx[i]   = cnt[i];
      rem_nx[i]   = rem[i];
      unique case (state[i])
        IDLE: begin
          if (start[i] && (c_num[i] != '0 || c_cont[i])) begin
            accept[i] = 1'b1;
            rem_nx[i] = c_num[i];
            if (c_dly[i] != '0) begin
              state_nx[i] = DELAY;
              cnt_nx[i]   = c_dly[i] - CNT_W'(1);
            end else begin
              state_nx[i] = HIGH;
              cnt_nx[i]   = len_m1(c_high[i]);
            end
          end
        end
        DELAY: begin
          if (cnt[i] == '0) begin
            state_nx[i] = HIGH;
            cnt_nx[i]   = len_m1(w_high[i]);
          end else begin
            cnt_nx[i] = cnt[i] - CNT_W'(1);
          end
        end
        HIGH: begin
          if (cnt[i] == '0) begin
            state_nx[i] = LOW;
            cnt_nx[i]   = len_m1(w_low[i]);
          end else begin
            cnt_nx[i] = cnt[i] - CNT_W'(1);
          end
        end
        LOW: begin
          if (cnt[i] == '0) begin
            rem_nx[i] = (rem[i] != '0) ? rem[i] - NUM_W'(1) : rem[i];
            if (w_cont[i] || rem[i] > NUM_W'(1)) begin
              state_nx[i] = HIGH;
              cnt_nx[i]   = len_m1(w_high[i]);
            end else begin
              state_nx[i] = IDLE;
              done_nx[i]  = 1'b1;
            end
          end else begin
            cnt_nx[i] = cnt[i] - CNT_W'(1);
          end
        end
        default: state_nx[i] = IDLE;
      endcase
      // Stop overrides both a pending start and a completing train.
      if (stop[i]) begin
        state_nx[i] = IDLE;
        accept[i]   = 1'b0;
        done_nx[i]  = 1'b0;
      end
    end
  end

  always_comb begin
    signal = '0;
    busy   = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      signal[i] = (state[i] == HIGH);
      busy[i]   = (state[i] != IDLE);
    end
    done = done_r;
  end

endmodule

// File: tb/tb_pulse_train_gen.sv
// Scoreboard bench for pulse_train_gen: an arithmetic timing model predicts
// every output cycle; a monitor process compares the DUT against the queue.
module tb_pulse_train_gen;

  localparam int NCH = 3;

  logic           clock = 1'b0;
  logic           reset;
  logic           cfg_we;
  logic [1:0]     cfg_ch;
  logic [7:0]     cfg_dly, cfg_high, cfg_low;
  logic [3:0]     cfg_num;
  logic           cfg_cont;
  logic [NCH-1:0] start, stop;
  logic [NCH-1:0] signal, busy, done;

  pulse_train_gen #(.CHANNELS(NCH), .CH_W(2), .CNT_W(8), .NUM_W(4)) dut (
    .clock(clock), .reset(reset), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_dly(cfg_dly), .cfg_high(cfg_high), .cfg_low(cfg_low),
    .cfg_num(cfg_num), .cfg_cont(cfg_cont), .start(start), .stop(stop),
    .signal(signal), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [NCH-1:0] s;
    logic [NCH-1:0] b;
    logic [NCH-1:0] d;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   edges = 0;

  // Model: configuration plus, per channel, the parameters of the current train.
  int m_dly[NCH], m_high[NCH], m_low[NCH], m_num[NCH];
  bit m_cont[NCH];
  bit r_v[NCH], r_cont[NCH];
  int r_k[NCH], r_D[NCH], r_H[NCH], r_L[NCH], r_N[NCH];

  always @(posedge clock) edges <= edges + 1;

  function automatic void model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_dly[c] = 0; m_high[c] = 1; m_low[c] = 1; m_num[c] = 1; m_cont[c] = 0;
      r_v[c] = 0;
    end
  endfunction

  function automatic int train_len(input int c);
    return r_D[c] + r_N[c] * (r_H[c] + r_L[c]);
  endfunction

  // Expected outputs of channel c in cycle cy (the cycle after edge cy-1).
  function automatic void exp_of(input int c, input int cy, output bit s, output bit b, output bit d);
    int t, u;
    s = 0; b = 0; d = 0;
    if (r_v[c]) begin
      t = cy - r_k[c] - 1;
      if (t < r_D[c]) b = 1;
      else begin
        u = t - r_D[c];
        if (r_cont[c] || u < r_N[c] * (r_H[c] + r_L[c])) begin
          b = 1;
          s = (u % (r_H[c] + r_L[c])) < r_H[c];
        end else if (u == r_N[c] * (r_H[c] + r_L[c])) d = 1;
      end
    end
  endfunction

  // Inputs are already set; predict the cycle after the coming edge, then clock.
  task automatic tick();
    exp_t x;
    bit s, b, d, idle;
    int e;
    e = edges;
    x = '0;
    if (reset) model_reset();
    else begin
      for (int c = 0; c < NCH; c++) begin
        idle = !r_v[c] || (!r_cont[c] && (e - r_k[c] - 1) >= train_len(c));
        if (stop[c]) r_v[c] = 0;
        else if (start[c] && idle && (m_num[c] != 0 || m_cont[c])) begin
          r_v[c] = 1; r_k[c] = e; r_D[c] = m_dly[c];
          r_H[c] = (m_high[c] == 0) ? 1 : m_high[c];
          r_L[c] = (m_low[c] == 0) ? 1 : m_low[c];
          r_N[c] = m_num[c]; r_cont[c] = m_cont[c];
        end
      end
      if (cfg_we && int'(cfg_ch) < NCH) begin
        m_dly[cfg_ch] = cfg_dly; m_high[cfg_ch] = cfg_high; m_low[cfg_ch] = cfg_low;
        m_num[cfg_ch] = cfg_num; m_cont[cfg_ch] = cfg_cont;
      end
      for (int c = 0; c < NCH; c++) begin
        exp_of(c, e + 1, s, b, d);
        x.s[c] = s; x.b[c] = b; x.d[c] = d;
      end
    end
    q.push_back(x);
    @(posedge clock);
    @(negedge clock);
    start = '0; stop = '0; cfg_we = 1'b0;
  endtask

  task automatic cfg(input int c, input int d, input int h, input int l, input int n, input bit ct);
    cfg_we = 1'b1; cfg_ch = 2'(c); cfg_dly = 8'(d); cfg_high = 8'(h);
    cfg_low = 8'(l); cfg_num = 4'(n); cfg_cont = ct;
  endtask

  task automatic check_now(input string name, input logic [NCH-1:0] act, input logic [NCH-1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %b, required %b", name, act, req);
    end
  endtask

  always @(posedge clock) begin
    exp_t x;
    #1;
    if (q.size() > 0) begin
      x = q.pop_front();
      tests++;
      if (signal !== x.s || busy !== x.b || done !== x.d) begin
        fails++;
        $display("FAIL outputs@edge%0d: signal=%b busy=%b done=%b, required signal=%b busy=%b done=%b",
                 edges, signal, busy, done, x.s, x.b, x.d);
      end
    end
  end

  initial begin
    reset = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_dly = '0; cfg_high = '0;
    cfg_low = '0; cfg_num = '0; cfg_cont = 1'b0; start = '0; stop = '0;
    model_reset();
    @(negedge clock);
    tick(); tick();
    reset = 1'b0;
    repeat (3) tick();

    // Default config: single one-cycle pulse.
    start = 3'b001; tick(); repeat (5) tick();

    // Finite train, retrigger attempt, mid-train config write, then a fresh start.
    cfg(1, 2, 4, 4, 3, 0); tick();
    start = 3'b010; tick(); repeat (4) tick();
    start = 3'b010; tick();
    cfg(1, 1, 2, 1, 2, 0); tick(); repeat (40) tick();
    start = 3'b010; tick(); repeat (15) tick();

    // Continuous square wave stopped after a while.
    cfg(2, 0, 5, 5, 0, 1); tick();
    start = 3'b100; tick(); repeat (45) tick();
    stop = 3'b100; tick(); repeat (5) tick();

    // Zero high/low lengths, zero pulse count, start+stop together, bad channel.
    cfg(0, 0, 0, 0, 2, 0); tick();
    start = 3'b001; tick(); repeat (6) tick();
    cfg(0, 0, 3, 3, 0, 0); tick();
    start = 3'b001; tick(); repeat (4) tick();
    cfg(1, 0, 1, 1, 1, 0); tick();
    start = 3'b010; stop = 3'b010; tick(); repeat (4) tick();
    cfg(3, 0, 7, 7, 9, 0); tick();
    start = 3'b111; tick(); repeat (6) tick();

    // Randomised traffic.
    repeat (3000) begin
      if ($urandom_range(0, 7) == 0)
        cfg($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 4),
            $urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 7) == 0);
      for (int c = 0; c < NCH; c++) begin
        start[c] = ($urandom_range(0, 7) == 0);
        stop[c]  = ($urandom_range(0, 39) == 0);
      end
      tick();
    end
    stop = '1; tick(); repeat (3) tick();

    // Asynchronous reset in the middle of a high phase.
    cfg(0, 1, 8, 2, 1, 0); tick();
    start = 3'b001; tick(); repeat (4) tick();
    check_now("mid_high_signal", signal, 3'b001);
    #2 reset = 1'b1;
    #1 check_now("async_signal", signal, '0);
    check_now("async_busy", busy, '0);
    check_now("async_done", done, '0);
    tick();
    reset = 1'b0;
    tick();
    start = 3'b001; tick(); repeat (5) tick();

    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1);
  end

endmodule
